// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter
// Shares one synchronous-read port of the boot/program ROM between the CPU
// instruction fetch (I) and the data bus (D). Each cycle it picks at most one
// requester, drives the ROM enable and word address, and tracks the read in
// flight. Two cycles after the grant it returns the registered ROM word to
// the owner with a one-cycle valid pulse. Throughput is one read per cycle.
module rom_port_arbiter #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int RR_MODE = 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_gnt,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_valid,

    input  logic              d_req,
    input  logic [31:0]       d_addr,
    output logic              d_gnt,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,

    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_do
);

    // Round-robin pointer encoding: which requester wins the next contended cycle.
    localparam logic PTR_I = 1'b0;
    localparam logic PTR_D = 1'b1;

    // Round-robin is a build-time choice; fixed priority always favours I.
    localparam logic RR_EN = (RR_MODE != 0);

    // Requester that wins the next contended cycle.
    logic rr_ptr;

    // Stage-1 tag: a read was issued last cycle, and whether D owns it.
    logic tag1_valid;
    logic tag1_is_d;

    // Arbitration result for this cycle.
    logic i_win;
    logic d_win;

    // Byte-offset and upper address bits are decoded upstream; they are
    // collected here only so that their non-use is explicit.
    logic unused_addr_bits;

    assign unused_addr_bits = ^{i_addr[31:ADDR_W+2], i_addr[1:0],
                                d_addr[31:ADDR_W+2], d_addr[1:0]};

    // Pick at most one requester; reset suppresses any grant this cycle.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise a path that skips an assignment infers a latch.
        i_win = 1'b0;
        d_win = 1'b0;
        if (!rst) begin
            if (i_req && d_req) begin
                if (RR_EN && (rr_ptr == PTR_D)) begin
                    d_win = 1'b1;
                end else begin
                    i_win = 1'b1;
                end
            end else begin
                i_win = i_req;
                d_win = d_req;
            end
        end
    end

    assign i_gnt  = i_win;
    assign d_gnt  = d_win;
    assign rom_en = i_win | d_win;

    // Word address of the granted requester (I when nobody is granted).
    assign rom_addr = d_win ? d_addr[ADDR_W+1:2] : i_addr[ADDR_W+1:2];

    // Pointer flips to the other requester after every grant.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (rst) begin
            rr_ptr <= PTR_I;
        end else if (i_win || d_win) begin
            rr_ptr <= i_win ? PTR_D : PTR_I;
        end
    end

    // Stage 1: remember whether a read was issued and who owns it.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag1_valid <= 1'b0;
            tag1_is_d  <= 1'b0;
        end else begin
            tag1_valid <= i_win | d_win;
            tag1_is_d  <= d_win;
        end
    end

    // Stage 2: capture the ROM word into the owner's register and pulse its valid.
    always_ff @(posedge clk) begin
        // NOTE: the read-data holding registers are reset because their
        // post-reset value is architecturally visible; this is a handful of
        // flops, not a memory array, so the reset costs nothing significant.
        if (rst) begin
            i_rdata <= '0;
            d_rdata <= '0;
            i_valid <= 1'b0;
            d_valid <= 1'b0;
        end else begin
            i_valid <= tag1_valid && !tag1_is_d;
            d_valid <= tag1_valid &&  tag1_is_d;
            if (tag1_valid && !tag1_is_d) begin
                i_rdata <= rom_do;
            end
            if (tag1_valid && tag1_is_d) begin
                d_rdata <= rom_do;
            end
        end
    end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb_rom_port_arbiter
// Directed bench for rom_port_arbiter. Two instances share the request
// inputs: one in round-robin mode, one in fixed-priority mode. Each has its
// own synchronous-read ROM model holding a small boot image.
module tb_rom_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic [31:0] d_addr;

    logic        rr_i_gnt, rr_i_valid, rr_d_gnt, rr_d_valid, rr_rom_en;
    logic [31:0] rr_i_rdata, rr_d_rdata, rr_rom_do;
    logic [8:0]  rr_rom_addr;

    logic        fp_i_gnt, fp_i_valid, fp_d_gnt, fp_d_valid, fp_rom_en;
    logic [31:0] fp_i_rdata, fp_d_rdata, fp_rom_do;
    logic [8:0]  fp_rom_addr;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rom_port_arbiter #(.ADDR_W(9), .DATA_W(32), .RR_MODE(1)) dut_rr (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(rr_i_gnt),
        .i_rdata(rr_i_rdata), .i_valid(rr_i_valid),
        .d_req(d_req), .d_addr(d_addr), .d_gnt(rr_d_gnt),
        .d_rdata(rr_d_rdata), .d_valid(rr_d_valid),
        .rom_en(rr_rom_en), .rom_addr(rr_rom_addr), .rom_do(rr_rom_do)
    );

    rom_port_arbiter #(.ADDR_W(9), .DATA_W(32), .RR_MODE(0)) dut_fp (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(fp_i_gnt),
        .i_rdata(fp_i_rdata), .i_valid(fp_i_valid),
        .d_req(d_req), .d_addr(d_addr), .d_gnt(fp_d_gnt),
        .d_rdata(fp_d_rdata), .d_valid(fp_d_valid),
        .rom_en(fp_rom_en), .rom_addr(fp_rom_addr), .rom_do(fp_rom_do)
    );

    // Boot image: the words the directed steps read, a filler pattern elsewhere.
    function automatic logic [31:0] rom_word(input logic [8:0] a);
        case (a)
            9'd0:    rom_word = 32'h08000010;
            9'd1:    rom_word = 32'h00000000;
            9'd2:    rom_word = 32'h3c08f060;
            9'd3:    rom_word = 32'had000000;
            9'd16:   rom_word = 32'h3c104000;
            default: rom_word = 32'hc0de0000 | {23'b0, a};
        endcase
    endfunction

    // Synchronous-read ROM models: data appears the cycle after the enable.
    always @(posedge clk) if (rr_rom_en) rr_rom_do <= rom_word(rr_rom_addr);
    always @(posedge clk) if (fp_rom_en) fp_rom_do <= rom_word(fp_rom_addr);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Move to the falling edge of the current cycle, where outputs are sampled.
    task automatic settle();
        @(negedge clk);
    endtask

    logic [31:0] stream_exp [3];

    initial begin
        stream_exp[0] = 32'h08000010;
        stream_exp[1] = 32'h00000000;
        stream_exp[2] = 32'h3c08f060;

        rst = 1'b1; i_req = 1'b0; d_req = 1'b0; i_addr = '0; d_addr = '0;
        tick(); tick();
        settle();
        check("reset i_valid", rr_i_valid, 1'b0);
        check("reset d_valid", rr_d_valid, 1'b0);
        check("reset i_rdata", rr_i_rdata, 32'h0);
        check("reset d_rdata", rr_d_rdata, 32'h0);
        check("reset rom_en",  rr_rom_en,  1'b0);
        tick();
        rst = 1'b0;

        // I alone reads word 0.
        i_req = 1'b1; i_addr = 32'h0;
        settle();
        check("t1 i_gnt",    rr_i_gnt,    1'b1);
        check("t1 d_gnt",    rr_d_gnt,    1'b0);
        check("t1 rom_en",   rr_rom_en,   1'b1);
        check("t1 rom_addr", rr_rom_addr, 9'd0);
        tick();
        i_req = 1'b0;
        settle();
        check("t1 i_valid early", rr_i_valid, 1'b0);
        tick();
        settle();
        check("t1 i_valid", rr_i_valid, 1'b1);
        check("t1 i_rdata", rr_i_rdata, 32'h08000010);
        check("t1 d_valid", rr_d_valid, 1'b0);
        tick();
        settle();
        check("t1 i_valid one pulse", rr_i_valid, 1'b0);
        tick();

        // D alone reads byte 0x40 = word 16.
        d_req = 1'b1; d_addr = 32'h40;
        settle();
        check("t2 d_gnt",    rr_d_gnt,    1'b1);
        check("t2 i_gnt",    rr_i_gnt,    1'b0);
        check("t2 rom_addr", rr_rom_addr, 9'd16);
        tick();
        d_req = 1'b0;
        settle();
        tick();
        settle();
        check("t2 d_valid", rr_d_valid, 1'b1);
        check("t2 d_rdata", rr_d_rdata, 32'h3c104000);
        check("t2 i_rdata held", rr_i_rdata, 32'h08000010);
        check("t2 i_valid", rr_i_valid, 1'b0);
        tick();

        // Both held for 4 cycles: round-robin alternates I,D,I,D.
        i_req = 1'b1; d_req = 1'b1; i_addr = 32'h8; d_addr = 32'hC;
        for (int c = 0; c < 6; c++) begin
            if (c == 4) begin
                i_req = 1'b0; d_req = 1'b0;
            end
            settle();
            check($sformatf("t3 c%0d rr i_gnt", c), rr_i_gnt, (c < 4) && (c % 2 == 0));
            check($sformatf("t3 c%0d rr d_gnt", c), rr_d_gnt, (c < 4) && (c % 2 == 1));
            check($sformatf("t3 c%0d i_valid", c), rr_i_valid, (c == 2) || (c == 4));
            check($sformatf("t3 c%0d d_valid", c), rr_d_valid, (c == 3) || (c == 5));
            check($sformatf("t3 c%0d i_rdata", c), rr_i_rdata,
                  (c >= 2) ? 32'h3c08f060 : 32'h08000010);
            check($sformatf("t3 c%0d d_rdata", c), rr_d_rdata,
                  (c >= 3) ? 32'had000000 : 32'h3c104000);
            if (c < 4) begin
                check($sformatf("t3 c%0d fp i_gnt", c), fp_i_gnt, 1'b1);
                check($sformatf("t3 c%0d fp d_gnt", c), fp_d_gnt, 1'b0);
            end
            tick();
        end

        // Fixed priority: I wins 3 cycles, D granted once i_req drops.
        i_req = 1'b1; d_req = 1'b1; i_addr = 32'h4; d_addr = 32'hC;
        for (int c = 0; c < 3; c++) begin
            settle();
            check($sformatf("t4 c%0d fp i_gnt", c), fp_i_gnt, 1'b1);
            check($sformatf("t4 c%0d fp d_gnt", c), fp_d_gnt, 1'b0);
            tick();
        end
        i_req = 1'b0;
        settle();
        check("t4 fp d_gnt after i drop", fp_d_gnt, 1'b1);
        check("t4 fp i_gnt after i drop", fp_i_gnt, 1'b0);
        tick();
        d_req = 1'b0;
        settle();
        tick();
        settle();
        check("t4 fp d_valid", fp_d_valid, 1'b1);
        check("t4 fp d_rdata", fp_d_rdata, 32'had000000);
        check("t4 fp i_valid", fp_i_valid, 1'b0);
        tick(); tick(); tick(); tick();

        // I streams words 0,1,2 back to back: three consecutive valids.
        d_req = 1'b0;
        for (int c = 0; c < 6; c++) begin
            i_req  = (c < 3);
            i_addr = 32'(c * 4);
            settle();
            check($sformatf("t5 c%0d i_gnt", c), rr_i_gnt, c < 3);
            check($sformatf("t5 c%0d i_valid", c), rr_i_valid, (c >= 2) && (c <= 4));
            check($sformatf("t5 c%0d d_valid", c), rr_d_valid, 1'b0);
            if (c >= 2 && c <= 4) begin
                check($sformatf("t5 c%0d i_rdata", c), rr_i_rdata, stream_exp[c-2]);
            end
            tick();
        end

        // Reset one cycle after a D grant: read discarded, grant suppressed.
        d_req = 1'b1; d_addr = 32'hC;
        settle();
        check("t6 d_gnt", rr_d_gnt, 1'b1);
        tick();
        d_req = 1'b0; rst = 1'b1; i_req = 1'b1; i_addr = 32'h0;
        settle();
        check("t6 i_gnt in reset", rr_i_gnt, 1'b0);
        check("t6 rom_en in reset", rr_rom_en, 1'b0);
        tick();
        rst = 1'b0; i_req = 1'b0;
        settle();
        check("t6 d_valid after reset", rr_d_valid, 1'b0);
        check("t6 d_rdata after reset", rr_d_rdata, 32'h0);
        check("t6 i_rdata after reset", rr_i_rdata, 32'h0);
        tick();
        settle();
        check("t6 d_valid 2nd cycle", rr_d_valid, 1'b0);
        check("t6 i_valid 2nd cycle", rr_i_valid, 1'b0);
        tick();

        // Pointer left at "D next" by an I grant, then reset: I must win.
        i_req = 1'b1; i_addr = 32'h8;
        settle();
        check("t7 i_gnt before reset", rr_i_gnt, 1'b1);
        tick();
        rst = 1'b1; d_req = 1'b1; d_addr = 32'h40;
        settle();
        check("t7 rom_en in reset", rr_rom_en, 1'b0);
        tick();
        rst = 1'b0;
        settle();
        check("t7 rr i_gnt after reset", rr_i_gnt, 1'b1);
        check("t7 rr d_gnt after reset", rr_d_gnt, 1'b0);
        check("t7 i_valid after reset", rr_i_valid, 1'b0);
        tick();
        settle();
        check("t7 rr d_gnt alternates", rr_d_gnt, 1'b1);
        check("t7 rr i_gnt alternates", rr_i_gnt, 1'b0);
        tick();
        i_req = 1'b0; d_req = 1'b0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
